// File: rtl/rv32i_mc_ctrl.sv
// Multi-cycle RV32I control sequencer: owns pc/IR, runs the fetch handshake,
// decodes immediates and steps each instruction through FETCH..WB.
module rv32i_mc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic        branch_taken,
    input  logic [31:0] jalr_target,
    output logic [31:0] pc,
    output logic [31:0] out_istr,
    output logic [4:0]  o_opcode,
    output logic [2:0]  o_funct3,
    output logic [6:0]  o_funct7,
    output logic [31:0] o_imm,
    output logic        rf_we,
    output logic [2:0]  state,
    output logic        illegal,
    output logic        halted,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_MISC   = 5'b00011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    state_t      cur, nxt;
    logic [4:0]  opc;
    logic        legal;
    logic        sys_halt;
    logic        writes_rd;
    logic        misaligned;
    logic [31:0] imm_dec;
    logic [31:0] next_pc;

    assign opc       = out_istr[6:2];
    assign o_opcode  = opc;
    assign o_funct3  = out_istr[14:12];
    assign o_funct7  = out_istr[31:25];
    assign state     = cur;
    assign imem_addr = pc;
    assign imem_req  = (cur == S_FETCH);
    assign dmem_req  = (cur == S_MEM);
    assign dmem_we   = (cur == S_MEM) && (opc == OPC_STORE);

    always_comb begin
        imm_dec = 32'h0;
        legal   = 1'b0;
        case (opc)
            OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM:
                imm_dec = {{20{out_istr[31]}}, out_istr[31:20]};
            OPC_STORE:
                imm_dec = {{20{out_istr[31]}}, out_istr[31:25], out_istr[11:7]};
            OPC_BRANCH:
                imm_dec = {{19{out_istr[31]}}, out_istr[31], out_istr[7],
                           out_istr[30:25], out_istr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm_dec = {out_istr[31:12], 12'h000};
            OPC_JAL:
                imm_dec = {{11{out_istr[31]}}, out_istr[31], out_istr[19:12],
                           out_istr[20], out_istr[30:21], 1'b0};
            default:
                imm_dec = 32'h0;
        endcase
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
            OPC_STORE, OPC_OPIMM, OPC_OP, OPC_MISC, OPC_SYSTEM:
                legal = (out_istr[1:0] == 2'b11);
            default:
                legal = 1'b0;
        endcase
    end

    assign sys_halt  = (opc == OPC_SYSTEM) && (out_istr[14:12] == 3'b000);
    assign writes_rd = ((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL) ||
                        (opc == OPC_JALR) || (opc == OPC_OPIMM) || (opc == OPC_OP) ||
                        (opc == OPC_LOAD)) && (out_istr[11:7] != 5'd0);

    // next_pc uses the immediate registered in DECODE, not the live decode
    always_comb begin
        next_pc = pc + 32'd4;
        case (opc)
            OPC_JAL:    next_pc = pc + o_imm;
            OPC_JALR:   next_pc = jalr_target & 32'hFFFF_FFFE;
            OPC_BRANCH: next_pc = branch_taken ? (pc + o_imm) : (pc + 32'd4);
            default:    next_pc = pc + 32'd4;
        endcase
    end

    assign misaligned = next_pc[1];
    assign rf_we      = (cur == S_WB) && writes_rd && !misaligned;

    always_comb begin
        nxt = cur;
        case (cur)
            S_IDLE:   nxt = S_FETCH;
            S_FETCH:  if (imem_ack) nxt = S_DECODE;
            S_DECODE: nxt = (!legal || sys_halt) ? S_TRAP : S_EXEC;
            S_EXEC:   nxt = ((opc == OPC_LOAD) || (opc == OPC_STORE)) ? S_MEM : S_WB;
            S_MEM:    if (dmem_ack) nxt = S_WB;
            S_WB:     nxt = misaligned ? S_TRAP : S_FETCH;
            S_TRAP:   nxt = S_TRAP;
            default:  nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur      <= S_IDLE;
            pc       <= RESET_PC;
            out_istr <= 32'h0;
            o_imm    <= 32'h0;
            instret  <= 32'h0;
            illegal  <= 1'b0;
            halted   <= 1'b0;
        end else begin
            cur <= nxt;
            if (cur == S_FETCH && imem_ack)
                out_istr <= imem_rdata;
            if (cur == S_DECODE) begin
                o_imm <= imm_dec;
                if (!legal)
                    illegal <= 1'b1;
                else if (sys_halt)
                    halted <= 1'b1;
            end
            if (cur == S_WB) begin
                if (misaligned) begin
                    illegal <= 1'b1;
                end else begin
                    pc      <= next_pc;
                    instret <= instret + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
// Self-checking bench for rv32i_mc_ctrl: a small pc/instret model plus a queue
// of per-instruction expectations pushed at fetch-ack and popped at decode/WB.
module tb_rv32i_mc_ctrl;

    localparam logic [4:0] T_JAL    = 5'b11011;
    localparam logic [4:0] T_JALR   = 5'b11001;
    localparam logic [4:0] T_BRANCH = 5'b11000;
    localparam logic [4:0] T_LOAD   = 5'b00000;
    localparam logic [4:0] T_STORE  = 5'b01000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, branch_taken;
    logic [31:0] imem_addr, imem_rdata, jalr_target, pc, out_istr, o_imm, instret;
    logic [4:0]  o_opcode;
    logic [2:0]  o_funct3, state;
    logic [6:0]  o_funct7;
    logic        rf_we, illegal, halted;

    typedef struct {
        logic [31:0] imm;
        logic        rfwe;
        int          kind;    // 0 normal, 1 illegal at decode, 2 halt at decode
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] m_pc;
    logic [31:0] m_instret;

    always #5 clk = ~clk;

    rv32i_mc_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .branch_taken(branch_taken), .jalr_target(jalr_target),
        .pc(pc), .out_istr(out_istr), .o_opcode(o_opcode), .o_funct3(o_funct3),
        .o_funct7(o_funct7), .o_imm(o_imm), .rf_we(rf_we), .state(state),
        .illegal(illegal), .halted(halted), .instret(instret)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        m_pc      = 32'h0;
        m_instret = 32'h0;
    endtask

    // Drives one instruction through the handshakes and checks every phase.
    task automatic run_instr(input logic [31:0] instr, input int iwait, input int dwait,
                             input logic taken, input logic [31:0] jt,
                             input logic [31:0] exp_imm, input logic exp_rfwe, input int kind);
        exp_t        e;
        int          cyc;
        int          guard;
        int          dcnt;
        int          exp_lat;
        logic        is_mem, is_store, mis;
        logic [4:0]  op;
        logic [31:0] npc;
        op       = instr[6:2];
        is_mem   = (op == T_LOAD) || (op == T_STORE);
        is_store = (op == T_STORE);
        exp_lat  = 4 + iwait + (is_mem ? 1 + dwait : 0);
        branch_taken = taken;
        jalr_target  = jt;
        guard = 0;
        while (state !== 3'd1 && guard < 20) begin
            step();
            guard++;
        end
        total++;
        if (state !== 3'd1) begin
            bad++;
            $display("FAIL fetch_timeout instr=%h state=%0d want=1", instr, state);
            return;
        end
        cyc = 1;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
            bad++;
            $display("FAIL fetch_req instr=%h req=%b addr=%h want req=1 addr=%h", instr, imem_req, imem_addr, m_pc);
        end
        for (int i = 0; i < iwait; i++) begin
            imem_ack   = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
            step();
            cyc++;
            total++;
            if (state !== 3'd1 || imem_req !== 1'b1 || imem_addr !== m_pc) begin
                bad++;
                $display("FAIL fetch_hold state=%0d req=%b addr=%h want 1/1/%h", state, imem_req, imem_addr, m_pc);
            end
        end
        imem_ack   = 1'b1;
        imem_rdata = instr;
        e.imm  = exp_imm;
        e.rfwe = exp_rfwe;
        e.kind = kind;
        sb.push_back(e);
        step();
        cyc++;
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        total++;
        if (state !== 3'd2 || out_istr !== instr || o_opcode !== instr[6:2] ||
            o_funct3 !== instr[14:12] || o_funct7 !== instr[31:25]) begin
            bad++;
            $display("FAIL decode state=%0d istr=%h op=%b f3=%b f7=%b want 2/%h", state, out_istr, o_opcode, o_funct3, o_funct7, instr);
        end
        step();
        cyc++;
        e = sb.pop_front();
        total++;
        if (o_imm !== e.imm) begin
            bad++;
            $display("FAIL imm instr=%h got=%h want=%h", instr, o_imm, e.imm);
        end
        if (e.kind != 0) begin
            total++;
            if (state !== 3'd6 || illegal !== (e.kind == 1) || halted !== (e.kind == 2) ||
                pc !== m_pc || instret !== m_instret) begin
                bad++;
                $display("FAIL decode_trap state=%0d ill=%b halt=%b pc=%h ir=%0d want 6/%b/%b/%h/%0d",
                         state, illegal, halted, pc, instret, e.kind == 1, e.kind == 2, m_pc, m_instret);
            end
            return;
        end
        total++;
        if (state !== 3'd3) begin
            bad++;
            $display("FAIL exec state=%0d want=3", state);
        end
        step();
        cyc++;
        if (is_mem) begin
            dcnt = 0;
            for (int i = 0; i < dwait; i++) begin
                if (dmem_req === 1'b1 && dmem_we === is_store) dcnt++;
                step();
                cyc++;
            end
            if (dmem_req === 1'b1 && dmem_we === is_store) dcnt++;
            dmem_ack = 1'b1;
            step();
            cyc++;
            dmem_ack = 1'b0;
            total++;
            if (dcnt != dwait + 1) begin
                bad++;
                $display("FAIL mem_req cycles=%0d want=%0d", dcnt, dwait + 1);
            end
        end
        npc = m_pc + 32'd4;
        if (op == T_JAL) npc = m_pc + e.imm;
        else if (op == T_JALR) npc = {jt[31:1], 1'b0};
        else if (op == T_BRANCH && taken) npc = m_pc + e.imm;
        mis = npc[1];
        total++;
        if (state !== 3'd5 || rf_we !== e.rfwe || cyc != exp_lat) begin
            bad++;
            $display("FAIL wb state=%0d rf_we=%b lat=%0d want 5/%b/%0d", state, rf_we, cyc, e.rfwe, exp_lat);
        end
        step();
        if (mis) begin
            total++;
            if (state !== 3'd6 || illegal !== 1'b1 || pc !== m_pc || instret !== m_instret || rf_we !== 1'b0) begin
                bad++;
                $display("FAIL misalign state=%0d ill=%b pc=%h ir=%0d want 6/1/%h/%0d", state, illegal, pc, instret, m_pc, m_instret);
            end
        end else begin
            m_pc = npc;
            m_instret++;
            total++;
            if (state !== 3'd1 || imem_req !== 1'b1 || pc !== m_pc || instret !== m_instret || rf_we !== 1'b0) begin
                bad++;
                $display("FAIL retire state=%0d req=%b pc=%h ir=%0d rf_we=%b want 1/1/%h/%0d/0",
                         state, imem_req, pc, instret, rf_we, m_pc, m_instret);
            end
        end
    endtask

    task automatic test_reset();
        imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = 32'h0;
        branch_taken = 1'b0; jalr_target = 32'h0;
        reset = 1'b1;
        step();
        total++;
        if (state !== 3'd0 || pc !== 32'h0 || out_istr !== 32'h0 || o_imm !== 32'h0 || instret !== 32'h0 ||
            imem_req !== 1'b0 || dmem_req !== 1'b0 || rf_we !== 1'b0 || illegal !== 1'b0 || halted !== 1'b0) begin
            bad++;
            $display("FAIL reset_state state=%0d pc=%h ir=%h imm=%h ret=%0d req=%b/%b we=%b ill=%b halt=%b",
                     state, pc, out_istr, o_imm, instret, imem_req, dmem_req, rf_we, illegal, halted);
        end
        reset = 1'b0;
        m_pc = 32'h0;
        m_instret = 32'h0;
        #1;
        total++;
        if (state !== 3'd0 || imem_req !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset state=%0d req=%b want 0/0", state, imem_req);
        end
        step();
        total++;
        if (state !== 3'd1 || imem_req !== 1'b1) begin
            bad++;
            $display("FAIL first_fetch state=%0d req=%b want 1/1", state, imem_req);
        end
    endtask

    task automatic test_addi();
        run_instr(32'h0050_0093, 0, 0, 1'b0, 32'h0, 32'h5, 1'b1, 0);
    endtask

    task automatic test_store();
        run_instr(32'h0011_2223, 0, 3, 1'b0, 32'h0, 32'h4, 1'b0, 0);
    endtask

    task automatic test_branch();
        run_instr(32'hFE00_0EE3, 0, 0, 1'b1, 32'h0, 32'hFFFF_FFFC, 1'b0, 0);
        run_instr(32'h0050_0093, 1, 0, 1'b0, 32'h0, 32'h5, 1'b1, 0);
        run_instr(32'hFE00_0EE3, 0, 0, 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b0, 0);
        total++;
        if (pc !== 32'd12) begin
            bad++;
            $display("FAIL branch_not_taken_pc got=%h want=0000000c", pc);
        end
    endtask

    task automatic test_back_to_back();
        run_instr(32'h1234_52B7, $urandom_range(0, 2), 0, 1'b0, 32'h0, 32'h1234_5000, 1'b1, 0);
        run_instr(32'h0000_1197, $urandom_range(0, 2), 0, 1'b0, 32'h0, 32'h0000_1000, 1'b1, 0);
        run_instr(32'h0080_00EF, 0, 0, 1'b0, 32'h0, 32'h0000_0008, 1'b1, 0);
        run_instr(32'h0020_8033, 0, 0, 1'b0, 32'h0, 32'h0, 1'b0, 0);
        run_instr(32'hFFF0_0093, $urandom_range(0, 2), 0, 1'b0, 32'h0, 32'hFFFF_FFFF, 1'b1, 0);
        run_instr(32'h0000_000F, 0, 0, 1'b0, 32'h0, 32'h0, 1'b0, 0);
        run_instr(32'h0040_2083, $urandom_range(0, 2), 0, 1'b0, 32'h0, 32'h4, 1'b1, 0);
    endtask

    task automatic test_illegal();
        int reqs;
        run_instr(32'h0000_0000, 0, 0, 1'b0, 32'h0, 32'h0, 1'b0, 1);
        reqs = 0;
        for (int i = 0; i < 6; i++) begin
            imem_ack = 1'b1;
            step();
            if (imem_req !== 1'b0 || rf_we !== 1'b0 || state !== 3'd6) reqs++;
        end
        imem_ack = 1'b0;
        total++;
        if (reqs != 0 || instret !== m_instret) begin
            bad++;
            $display("FAIL trap_quiet active_cycles=%0d instret=%0d want 0/%0d", reqs, instret, m_instret);
        end
        do_reset();
        total++;
        if (pc !== 32'h0 || illegal !== 1'b0 || state !== 3'd0) begin
            bad++;
            $display("FAIL trap_reset pc=%h ill=%b state=%0d want 0/0/0", pc, illegal, state);
        end
    endtask

    task automatic test_jalr();
        run_instr(32'h0001_00E7, 0, 0, 1'b0, 32'h0000_0102, 32'h0, 1'b0, 0);
        do_reset();
        run_instr(32'h0001_00E7, 0, 0, 1'b0, 32'h0000_0101, 32'h0, 1'b1, 0);
        total++;
        if (pc !== 32'h100) begin
            bad++;
            $display("FAIL jalr_pc got=%h want=00000100", pc);
        end
    endtask

    task automatic test_ecall();
        run_instr(32'h0000_0073, 0, 0, 1'b0, 32'h0, 32'h0, 1'b0, 2);
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        run_instr(32'h0050_0093, 0, 0, 1'b0, 32'h0, 32'h5, 1'b1, 0);
        imem_ack = 1'b1;
        imem_rdata = 32'h0040_2083;
        step();
        imem_ack = 1'b0;
        step();
        step();
        step();
        total++;
        if (state !== 3'd4 || dmem_req !== 1'b1 || dmem_we !== 1'b0) begin
            bad++;
            $display("FAIL load_mem state=%0d req=%b we=%b want 4/1/0", state, dmem_req, dmem_we);
        end
        reset = 1'b1;
        #1;
        total++;
        if (dmem_req !== 1'b0 || state !== 3'd0 || pc !== 32'h0 || instret !== 32'h0) begin
            bad++;
            $display("FAIL async_reset req=%b state=%0d pc=%h ir=%0d want 0/0/0/0", dmem_req, state, pc, instret);
        end
        step();
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_store();
        test_branch();
        test_back_to_back();
        test_illegal();
        test_jalr();
        test_ecall();
        test_reset_mid_mem();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv32i_mc_ctrl.md
# rv32i_mc_ctrl

Multi-cycle control sequencer for the RV32I core. Owns the program counter and instruction register, fetches over a request/ack instruction-memory handshake, decodes opcode/funct/immediate fields for the datapath, and steps each instruction through FETCH, DECODE, EXEC, optional MEM, and WB. Sits between the memories and the register-file/ALU datapath inside `CPU`, and drives `CPU`'s `out_istr`/`o_*` debug outputs.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- imem_req  out  1  instruction fetch request; high only in FETCH
- imem_addr  out  32  equals pc
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction
- dmem_req  out  1  data access request; high only in MEM
- dmem_we  out  1  1 = store; valid with dmem_req
- dmem_ack  in  1  data access complete
- branch_taken  in  1  datapath comparator result for current BRANCH
- jalr_target  in  32  rs1+imm from datapath
- pc  out  32  current instruction address
- out_istr  out  32  latched instruction register
- o_opcode  out  5  out_istr[6:2]
- o_funct3  out  3  out_istr[14:12]
- o_funct7  out  7  out_istr[31:25]
- o_imm  out  32  sign-extended immediate, registered in DECODE
- rf_we  out  1  register-file write strobe, one cycle in WB
- state  out  3  IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 TRAP=6
- illegal  out  1  sticky: illegal instruction or misaligned target
- halted  out  1  sticky: ECALL/EBREAK reached
- instret  out  32  retired-instruction count, wraps at 2^32

## Operation
- Reset: state IDLE, pc=RESET_PC, out_istr=0, o_imm=0, instret=0; all strobes, illegal, halted = 0. Reset asserted mid-operation aborts any transaction immediately (asynchronous); req outputs drop the same cycle.
- IDLE -> FETCH unconditionally.
- FETCH: imem_req=1, imem_addr=pc, held stable until imem_ack. On ack: out_istr <= imem_rdata, -> DECODE.
- DECODE: o_imm registered by format: I (LOAD, OP-IMM, JALR, SYSTEM), S (STORE), B (BRANCH), U (LUI, AUIPC), J (JAL); OP and MISC-MEM -> 0. Sign bit is inst[31]. Legal iff inst[1:0]=2'b11 and opcode in {01101, 00101, 11011, 11001, 11000, 00000, 01000, 00100, 01100, 00011, 11100}. Illegal -> TRAP, illegal=1. SYSTEM with funct3=0 -> TRAP, halted=1. Otherwise -> EXEC.
- EXEC: one cycle. LOAD/STORE -> MEM; else -> WB.
- MEM: dmem_req=1, dmem_we=1 for STORE. Held until dmem_ack, then -> WB.
- WB: next-PC computed as follows.
  - JAL: pc+o_imm.
  - JALR: jalr_target with bit 0 cleared.
  - BRANCH: pc+o_imm if branch_taken, else pc+4.
  - Others: pc+4.
  - If next-PC[1]=1 -> TRAP, illegal=1; pc, rf_we and instret unchanged.
  - Else pc <= next-PC, instret += 1, -> FETCH.
  - rf_we=1 for LUI, AUIPC, JAL, JALR, OP-IMM, OP, LOAD when rd (inst[11:7]) != 0.
- TRAP: terminal. No req or rf_we. Only reset exits.
- Adds are 32-bit and wrap modulo 2^32.

## Timing
- imem_ack/dmem_ack may assert in the first cycle of the request (zero wait). An ack outside FETCH/MEM is ignored.
- Zero-wait latency: non-memory instruction 4 cycles (FETCH, DECODE, EXEC, WB); LOAD/STORE 5 cycles. Each ack wait state adds one cycle.
- First imem_req is asserted in the second cycle after reset deasserts (IDLE occupies the first).
- pc, instret and out_istr update on the clock edge leaving WB or FETCH respectively. rf_we and o_imm are valid throughout WB.

## Test plan
- Reset release, imem returns 0x00500093 (ADDI x1,x0,5) with zero wait -> o_opcode=00100, o_imm=5, rf_we one cycle in WB, pc 0->4, instret=1, imem_req again 4 cycles after first.
- SW x1,4(x2) = 0x00112223, dmem_ack delayed 3 cycles -> o_imm=4, dmem_req=dmem_we=1 for 4 cycles, rf_we=0, pc+=4, total 8 cycles.
- At pc=8, BEQ 0xFE000EE3 with branch_taken=1 -> o_imm=0xFFFFFFFC, pc=4. Repeat with branch_taken=0 -> pc=12.
- Fetch 0x00000000 -> TRAP, illegal=1, no further imem_req, instret unchanged. Then pulse reset -> pc=RESET_PC, illegal=0.
- JALR with jalr_target=0x102 -> TRAP, illegal=1, pc unchanged. Repeat with 0x101 -> pc=0x100.
- ECALL 0x00000073 -> halted=1, state=6. Additionally, assert reset during MEM wait -> dmem_req drops the same cycle, state=IDLE.
